// File: rtl/apb_arbiter.sv
// Round-robin arbiter that shares one downstream APB master port between NUM_REQ requesters.
// Defining APB_ARB_TIMEOUT_EN adds an ACCESS-phase watchdog and the sticky timeout_flag output.
module apb_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = 13,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                          PCLK,
    input  logic                          PRESET,
    input  logic [NUM_REQ-1:0]            s_PSEL,
    input  logic [NUM_REQ-1:0]            s_PENABLE,
    input  logic [NUM_REQ-1:0]            s_PWRITE,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] s_PADDR,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_PWDATA,
    output logic [NUM_REQ-1:0]            s_PREADY,
    output logic [NUM_REQ-1:0]            s_PSLVERR,
    output logic [DATA_WIDTH-1:0]         s_PRDATA,
    output logic                          m_PSEL,
    output logic                          m_PENABLE,
    output logic                          m_PWRITE,
    output logic [ADDR_WIDTH-1:0]         m_PADDR,
    output logic [DATA_WIDTH-1:0]         m_PWDATA,
    input  logic                          m_PREADY,
    input  logic                          m_PSLVERR,
    input  logic [DATA_WIDTH-1:0]         m_PRDATA
`ifdef APB_ARB_TIMEOUT_EN
    ,
    output logic                          timeout_flag
`endif
);

    localparam int          GRANT_W = $clog2(NUM_REQ);
    localparam int unsigned NREQ_U  = NUM_REQ;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t               state;
    logic [GRANT_W-1:0]   grant;
    logic [GRANT_W-1:0]   last_grant;
    logic [GRANT_W-1:0]   next_grant;
    logic                 any_req;
    logic [NUM_REQ-1:0]   grant_onehot;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] timeout_cnt;
`endif

    // s_PENABLE is carried for requester-side protocol checking only.
    logic unused_ok;
    assign unused_ok = &{1'b0, s_PENABLE, (TIMEOUT_CYCLES != 0)};

    // Search starts one past the last grant, so the previous winner has lowest priority.
    always_comb begin
        int unsigned idx;
        logic [GRANT_W-1:0] idx_g;
        next_grant = '0;
        any_req    = 1'b0;
        idx        = 0;
        idx_g      = '0;
        for (int unsigned off = 1; off <= NREQ_U; off++) begin
            idx = 32'(last_grant) + off;
            if (idx >= NREQ_U) begin
                idx = idx - NREQ_U;
            end
            idx_g = GRANT_W'(idx);
            if (!any_req && s_PSEL[idx_g]) begin
                any_req    = 1'b1;
                next_grant = idx_g;
            end
        end
    end

    always_comb begin
        grant_onehot        = '0;
        grant_onehot[grant] = 1'b1;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= GRANT_W'(NUM_REQ - 1);
            m_PSEL     <= 1'b0;
            m_PENABLE  <= 1'b0;
            m_PWRITE   <= 1'b0;
            m_PADDR    <= '0;
            m_PWDATA   <= '0;
            s_PREADY   <= '0;
            s_PSLVERR  <= '0;
            s_PRDATA   <= '0;
`ifdef APB_ARB_TIMEOUT_EN
            timeout_cnt  <= '0;
            timeout_flag <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant      <= next_grant;
                        last_grant <= next_grant;
                        m_PWRITE   <= s_PWRITE[next_grant];
                        m_PADDR    <= s_PADDR[next_grant*ADDR_WIDTH +: ADDR_WIDTH];
                        m_PWDATA   <= s_PWDATA[next_grant*DATA_WIDTH +: DATA_WIDTH];
                        m_PSEL     <= 1'b1;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    m_PENABLE <= 1'b1;
                    state     <= ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
                    timeout_cnt <= '0;
`endif
                end
                ACCESS: begin
                    if (m_PREADY) begin
                        m_PSEL    <= 1'b0;
                        m_PENABLE <= 1'b0;
                        s_PREADY  <= grant_onehot;
                        s_PSLVERR <= m_PSLVERR ? grant_onehot : '0;
                        s_PRDATA  <= m_PRDATA;
                        state     <= RESP;
                    end
`ifdef APB_ARB_TIMEOUT_EN
                    else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                        // The cycle that brings the count to the limit closes the transfer as an error.
                        if ((timeout_cnt + 1'b1) == CNT_W'(TIMEOUT_CYCLES)) begin
                            m_PSEL       <= 1'b0;
                            m_PENABLE    <= 1'b0;
                            s_PREADY     <= grant_onehot;
                            s_PSLVERR    <= grant_onehot;
                            s_PRDATA     <= '0;
                            timeout_flag <= 1'b1;
                            state        <= RESP;
                        end
                    end
`endif
                end
                RESP: begin
                    s_PREADY  <= '0;
                    s_PSLVERR <= '0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_arbiter.sv
// Self-checking bench for apb_arbiter: directed scenarios plus randomized traffic against a
// transaction-level round-robin model. Timeout scenario runs only with APB_ARB_TIMEOUT_EN.
module tb_apb_arbiter;

    localparam int NR = 3;
    localparam int AW = 13;
    localparam int DW = 32;
`ifdef APB_ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 256;
`endif

    logic                PCLK = 1'b0;
    logic                PRESET;
    logic [NR-1:0]       s_PSEL, s_PENABLE, s_PWRITE;
    logic [NR*AW-1:0]    s_PADDR;
    logic [NR*DW-1:0]    s_PWDATA;
    logic [NR-1:0]       s_PREADY, s_PSLVERR;
    logic [DW-1:0]       s_PRDATA;
    logic                m_PSEL, m_PENABLE, m_PWRITE;
    logic [AW-1:0]       m_PADDR;
    logic [DW-1:0]       m_PWDATA;
    logic                m_PREADY, m_PSLVERR;
    logic [DW-1:0]       m_PRDATA;
`ifdef APB_ARB_TIMEOUT_EN
    logic                timeout_flag;
`endif

    int checks   = 0;
    int failures = 0;

    logic [NR-1:0] req;
    logic [AW-1:0] r_addr  [NR];
    logic [DW-1:0] r_data  [NR];
    logic          r_write [NR];
    int            model_last;

    apb_arbiter #(
        .NUM_REQ(NR),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .PCLK(PCLK),
        .PRESET(PRESET),
        .s_PSEL(s_PSEL),
        .s_PENABLE(s_PENABLE),
        .s_PWRITE(s_PWRITE),
        .s_PADDR(s_PADDR),
        .s_PWDATA(s_PWDATA),
        .s_PREADY(s_PREADY),
        .s_PSLVERR(s_PSLVERR),
        .s_PRDATA(s_PRDATA),
        .m_PSEL(m_PSEL),
        .m_PENABLE(m_PENABLE),
        .m_PWRITE(m_PWRITE),
        .m_PADDR(m_PADDR),
        .m_PWDATA(m_PWDATA),
        .m_PREADY(m_PREADY),
        .m_PSLVERR(m_PSLVERR),
        .m_PRDATA(m_PRDATA)
`ifdef APB_ARB_TIMEOUT_EN
        ,
        .timeout_flag(timeout_flag)
`endif
    );

    always #5 PCLK = ~PCLK;

    task automatic drive();
        s_PSEL    = req;
        s_PENABLE = req;
        for (int i = 0; i < NR; i++) begin
            s_PWRITE[i]          = r_write[i];
            s_PADDR[i*AW +: AW]  = r_addr[i];
            s_PWDATA[i*DW +: DW] = r_data[i];
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    // Reference round-robin: first requesting index after the previous winner, wrapping.
    function automatic int rr_pick(input logic [NR-1:0] v, input int last);
        for (int k = 1; k <= NR; k++) begin
            if (v[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    task automatic test_reset();
        repeat (2) @(posedge PCLK);
        #1;
        checks++; if ({m_PSEL, m_PENABLE, m_PWRITE} !== 3'b000) begin failures++; $display("FAIL reset_m_ctrl got=%b exp=000", {m_PSEL, m_PENABLE, m_PWRITE}); end
        checks++; if (m_PADDR !== '0) begin failures++; $display("FAIL reset_m_paddr got=%h exp=0", m_PADDR); end
        checks++; if (m_PWDATA !== '0) begin failures++; $display("FAIL reset_m_pwdata got=%h exp=0", m_PWDATA); end
        checks++; if ({s_PREADY, s_PSLVERR} !== '0) begin failures++; $display("FAIL reset_s_resp got=%b exp=0", {s_PREADY, s_PSLVERR}); end
        checks++; if (s_PRDATA !== '0) begin failures++; $display("FAIL reset_s_prdata got=%h exp=0", s_PRDATA); end
        PRESET = 1'b0;
        model_last = NR - 1;
        step();
        checks++; if (m_PSEL !== 1'b0) begin failures++; $display("FAIL idle_no_req got=%b exp=0", m_PSEL); end
    endtask

    task automatic test_single_write();
        r_addr[1] = 13'h010; r_data[1] = 32'hA5A5_0001; r_write[1] = 1'b1;
        req = 3'b010; m_PREADY = 1'b1; m_PSLVERR = 1'b0; m_PRDATA = 32'h1111_2222;
        drive();
        step();
        checks++; if ({m_PSEL, m_PENABLE} !== 2'b10) begin failures++; $display("FAIL wr_c1_psel_pen got=%b exp=10", {m_PSEL, m_PENABLE}); end
        checks++; if (m_PADDR !== 13'h010) begin failures++; $display("FAIL wr_c1_paddr got=%h exp=010", m_PADDR); end
        checks++; if ({m_PWRITE, m_PWDATA} !== {1'b1, 32'hA5A5_0001}) begin failures++; $display("FAIL wr_c1_wdata got=%b/%h exp=1/a5a50001", m_PWRITE, m_PWDATA); end
        step();
        checks++; if ({m_PSEL, m_PENABLE, s_PREADY} !== 5'b11_000) begin failures++; $display("FAIL wr_c2 got=%b exp=11000", {m_PSEL, m_PENABLE, s_PREADY}); end
        step();
        checks++; if ({s_PREADY, s_PSLVERR} !== 6'b010_000) begin failures++; $display("FAIL wr_c3_resp got=%b exp=010000", {s_PREADY, s_PSLVERR}); end
        checks++; if ({m_PSEL, m_PENABLE} !== 2'b00) begin failures++; $display("FAIL wr_c3_mdrop got=%b exp=00", {m_PSEL, m_PENABLE}); end
        req = '0; drive();
        step();
        checks++; if (s_PREADY !== '0) begin failures++; $display("FAIL wr_c4_pulse got=%b exp=000", s_PREADY); end
        model_last = 1;
    endtask

    task automatic test_read_wait();
        int acc = 0;
        int lat = 0;
        r_addr[0] = 13'h1F4; r_write[0] = 1'b0; r_data[0] = 32'h0;
        req = 3'b001; m_PREADY = 1'b0; m_PRDATA = 32'hDEADBEEF;
        drive();
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            step();
            if (s_PREADY !== '0) lat = c;
            else begin
                if (m_PSEL && m_PENABLE) acc++;
                m_PREADY = (acc == 4);
            end
        end
        checks++; if (lat != 6) begin failures++; $display("FAIL rd_latency got=%0d exp=6", lat); end
        checks++; if (s_PREADY !== 3'b001) begin failures++; $display("FAIL rd_pready got=%b exp=001", s_PREADY); end
        checks++; if (s_PRDATA !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_prdata got=%h exp=deadbeef", s_PRDATA); end
        m_PREADY = 1'b0; req = '0; drive();
        step();
        model_last = 0;
    endtask

    task automatic test_contention();
        int setups = 0;
        int resps = 0;
        int last_setup = 0;
        logic [NR-1:0] oh;
        PRESET = 1'b1; req = '0; drive(); step(); PRESET = 1'b0;
        r_addr[0] = 13'h0A0; r_data[0] = 32'h0000_00A0; r_write[0] = 1'b1;
        r_addr[1] = 13'h0B1; r_data[1] = 32'h0000_00B1; r_write[1] = 1'b0;
        req = 3'b011; m_PREADY = 1'b1; m_PSLVERR = 1'b0; drive();
        for (int c = 1; c <= 40 && resps < 4; c++) begin
            step();
            if (m_PSEL && !m_PENABLE) begin
                checks++; if (m_PADDR !== r_addr[setups % 2]) begin failures++; $display("FAIL cont_paddr_%0d got=%h exp=%h", setups, m_PADDR, r_addr[setups % 2]); end
                if (setups > 0) begin
                    checks++; if (c - last_setup != 4) begin failures++; $display("FAIL cont_spacing_%0d got=%0d exp=4", setups, c - last_setup); end
                end
                last_setup = c;
                setups++;
            end
            if (s_PREADY !== '0) begin
                oh = '0; oh[resps % 2] = 1'b1;
                checks++; if (s_PREADY !== oh) begin failures++; $display("FAIL cont_pready_%0d got=%b exp=%b", resps, s_PREADY, oh); end
                resps++;
                if (resps == 4) begin req = '0; drive(); end
            end
        end
        checks++; if (resps != 4) begin failures++; $display("FAIL cont_timeout got=%0d exp=4", resps); end
        step();
        model_last = 1;
    endtask

    task automatic test_slave_error();
        int g;
        int seen = 0;
        logic [NR-1:0] oh;
        req = 3'b011; m_PREADY = 1'b1; m_PSLVERR = 1'b1; m_PRDATA = $urandom; drive();
        g = rr_pick(req, model_last);
        oh = '0; oh[g] = 1'b1;
        for (int c = 1; c <= 20 && seen == 0; c++) begin
            step();
            if (s_PREADY !== '0) seen = 1;
        end
        checks++; if (s_PREADY !== oh) begin failures++; $display("FAIL err_pready got=%b exp=%b", s_PREADY, oh); end
        checks++; if (s_PSLVERR !== oh) begin failures++; $display("FAIL err_pslverr got=%b exp=%b", s_PSLVERR, oh); end
        req = '0; m_PSLVERR = 1'b0; drive();
        step();
        checks++; if (s_PSLVERR !== '0) begin failures++; $display("FAIL err_clear got=%b exp=000", s_PSLVERR); end
        model_last = g;
    endtask

    task automatic test_reset_access();
        r_addr[0] = 13'h033; r_write[0] = 1'b1; r_data[0] = 32'h3333_0000;
        r_addr[1] = 13'h044; r_write[1] = 1'b0;
        req = 3'b001; m_PREADY = 1'b0; drive();
        step(); step(); step();
        checks++; if ({m_PSEL, m_PENABLE} !== 2'b11) begin failures++; $display("FAIL rst_pre_access got=%b exp=11", {m_PSEL, m_PENABLE}); end
        #2 PRESET = 1'b1;
        #1;
        checks++; if ({m_PSEL, m_PENABLE} !== 2'b00) begin failures++; $display("FAIL rst_async_drop got=%b exp=00", {m_PSEL, m_PENABLE}); end
        m_PREADY = 1'b1;
        step();
        checks++; if (s_PREADY !== '0) begin failures++; $display("FAIL rst_no_pready got=%b exp=000", s_PREADY); end
        req = 3'b011; drive();
        PRESET = 1'b0;
        model_last = NR - 1;
        step();
        checks++; if ({m_PSEL, m_PADDR} !== {1'b1, 13'h033}) begin failures++; $display("FAIL rst_first_grant got=%b/%h exp=1/033", m_PSEL, m_PADDR); end
        step(); step();
        checks++; if (s_PREADY !== 3'b001) begin failures++; $display("FAIL rst_first_resp got=%b exp=001", s_PREADY); end
        req = '0; drive();
        step();
        model_last = 0;
    endtask

`ifdef APB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int lat = 0;
        r_addr[2] = 13'h1AB; r_write[2] = 1'b0;
        req = 3'b100; m_PREADY = 1'b0; m_PRDATA = 32'hFFFF_FFFF; drive();
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            step();
            if (c == 1) begin
                checks++; if (timeout_flag !== 1'b0) begin failures++; $display("FAIL to_flag_early got=%b exp=0", timeout_flag); end
            end
            if (s_PREADY !== '0) lat = c;
        end
        checks++; if (lat != 2 + TO) begin failures++; $display("FAIL to_latency got=%0d exp=%0d", lat, 2 + TO); end
        checks++; if ({s_PREADY, s_PSLVERR} !== 6'b100_100) begin failures++; $display("FAIL to_resp got=%b exp=100100", {s_PREADY, s_PSLVERR}); end
        checks++; if (s_PRDATA !== '0) begin failures++; $display("FAIL to_prdata got=%h exp=0", s_PRDATA); end
        checks++; if ({timeout_flag, m_PSEL, m_PENABLE} !== 3'b100) begin failures++; $display("FAIL to_flag_mdrop got=%b exp=100", {timeout_flag, m_PSEL, m_PENABLE}); end
        req = '0; drive(); step();
        r_addr[0] = 13'h055; req = 3'b001; m_PREADY = 1'b1; m_PSLVERR = 1'b0; drive();
        step(); step(); step();
        checks++; if ({s_PREADY, s_PSLVERR, timeout_flag} !== 7'b001_000_1) begin failures++; $display("FAIL to_next_xfer got=%b exp=0010001", {s_PREADY, s_PSLVERR, timeout_flag}); end
        req = '0; drive(); step();
        model_last = 0;
    endtask
`endif

    task automatic test_random_traffic(input int n);
        int g, waits, idx;
        int skip [NR];
        logic err;
        logic [DW-1:0] rd;
        logic [NR-1:0] vec, oh;
        for (int i = 0; i < NR; i++) skip[i] = 0;
        for (int t = 0; t < n; t++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req[i] && $urandom_range(1, 0) == 1) begin
                    req[i] = 1'b1; skip[i] = 0;
                    r_addr[i] = AW'($urandom); r_data[i] = $urandom; r_write[i] = 1'($urandom);
                end
            end
            if (req == '0) begin
                m_PREADY = 1'($urandom); drive(); step();
                checks++; if ({m_PSEL, s_PREADY} !== '0) begin failures++; $display("FAIL rnd_idle_%0d got=%b exp=0", t, {m_PSEL, s_PREADY}); end
                idx = $urandom_range(NR - 1, 0);
                req[idx] = 1'b1; skip[idx] = 0;
                r_addr[idx] = AW'($urandom); r_data[idx] = $urandom; r_write[idx] = 1'($urandom);
            end
            vec = req;
            g = rr_pick(vec, model_last);
            m_PREADY = 1'($urandom); drive(); step();
            checks++; if ({m_PSEL, m_PENABLE, s_PREADY} !== {2'b10, {NR{1'b0}}}) begin failures++; $display("FAIL rnd_setup_%0d got=%b exp=10 000", t, {m_PSEL, m_PENABLE, s_PREADY}); end
            checks++; if ({m_PWRITE, m_PADDR, m_PWDATA} !== {r_write[g], r_addr[g], r_data[g]}) begin failures++; $display("FAIL rnd_grant_%0d got=%b/%h/%h exp=req%0d %b/%h/%h", t, m_PWRITE, m_PADDR, m_PWDATA, g, r_write[g], r_addr[g], r_data[g]); end
            for (int i = 0; i < NR; i++) begin
                if (i != g && vec[i]) begin
                    skip[i]++;
                    checks++; if (skip[i] > NR - 1) begin failures++; $display("FAIL rnd_fair_%0d req%0d got=%0d exp<=%0d", t, i, skip[i], NR - 1); end
                end
            end
            skip[g] = 0;
            waits = $urandom_range(3, 0);
            m_PREADY = 1'($urandom); step();
            for (int w = 0; w < waits; w++) begin
                m_PREADY = 1'b0; step();
                checks++; if ({m_PENABLE, s_PREADY} !== {1'b1, {NR{1'b0}}}) begin failures++; $display("FAIL rnd_wait_%0d got=%b exp=1 000", t, {m_PENABLE, s_PREADY}); end
            end
            err = 1'($urandom); rd = $urandom;
            m_PREADY = 1'b1; m_PSLVERR = err; m_PRDATA = rd; step();
            oh = '0; oh[g] = 1'b1;
            checks++; if ({s_PREADY, s_PSLVERR} !== {oh, (err ? oh : {NR{1'b0}})}) begin failures++; $display("FAIL rnd_resp_%0d got=%b/%b exp=%b/%b", t, s_PREADY, s_PSLVERR, oh, err ? oh : {NR{1'b0}}); end
            checks++; if ({m_PSEL, m_PENABLE, s_PRDATA} !== {2'b00, rd}) begin failures++; $display("FAIL rnd_rdata_%0d got=%b/%h exp=00/%h", t, {m_PSEL, m_PENABLE}, s_PRDATA, rd); end
            m_PREADY = 1'($urandom); m_PSLVERR = 1'($urandom); m_PRDATA = $urandom;
            req[g] = 1'($urandom);
            if (req[g]) begin
                r_addr[g] = AW'($urandom); r_data[g] = $urandom; r_write[g] = 1'($urandom);
            end
            drive(); step();
            checks++; if ({s_PREADY, s_PSLVERR, m_PSEL, s_PRDATA} !== {{(2*NR+1){1'b0}}, rd}) begin failures++; $display("FAIL rnd_after_%0d got=%b/%h exp=0/%h", t, {s_PREADY, s_PSLVERR, m_PSEL}, s_PRDATA, rd); end
            model_last = g;
        end
        req = '0; drive(); step();
    endtask

    initial begin
        PRESET = 1'b1;
        req = '0;
        for (int i = 0; i < NR; i++) begin r_addr[i] = '0; r_data[i] = '0; r_write[i] = 1'b0; end
        m_PREADY = 1'b0; m_PSLVERR = 1'b0; m_PRDATA = '0;
        drive();
        test_reset();
        test_single_write();
        test_read_wait();
        test_contention();
        test_slave_error();
        test_reset_access();
`ifdef APB_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random_traffic(60);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=no_finish exp=finish checks=%0d failures=%0d", checks, failures);
        $fatal(1, "simulation watchdog expired");
    end

endmodule
